// File: rtl/mac_pkg.sv
// mac_pkg: types and constants shared across the MAC datapath stages.
package mac_pkg;

    localparam int PRODUCT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: product stream in, finished dot-product out.
interface mac_accumulator_if #(parameter int ACC_W = 8);
    import mac_pkg::*;

    logic                 start;
    logic                 in_valid;
    logic [PRODUCT_W-1:0] product;
    logic                 in_ready;
    logic [ACC_W-1:0]     acc_out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 overflow;

    modport master (
        output start, in_valid, product, out_ready,
        input  in_ready, acc_out, out_valid, overflow
    );

    modport slave (
        input  start, in_valid, product, out_ready,
        output in_ready, acc_out, out_valid, overflow
    );

endinterface

// File: rtl/mac_accumulator_ripple_adder.sv
// ripple_adder: ACC_W-bit ripple-carry adder from gate-level full-adder cells.
module ripple_adder #(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             cout
);

    logic [ACC_W:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < ACC_W; i++) begin : g_fa
        logic p, g, t;
        xor u_p (p, a[i], b[i]);
        xor u_s (sum[i], p, c[i]);
        and u_g (g, a[i], b[i]);
        and u_t (t, p, c[i]);
        or  u_c (c[i+1], g, t);
    end

    assign cout = c[ACC_W];

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums N_TERMS products into a wrapping accumulator with a
// sticky overflow flag and hands the result out over a valid/ready handshake.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W   = 8,
    parameter int N_TERMS = 4
) (
    input logic                clk,
    input logic                rst_n,
    mac_accumulator_if.slave   bus
);

    localparam int               CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_TERMS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] addend, sum;
    logic             cout;

    always_comb begin
        addend                  = '0;
        addend[PRODUCT_W-1:0]   = bus.product;
    end

    ripple_adder #(.ACC_W(ACC_W)) u_adder (
        .a    (acc_q),
        .b    (addend),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = ACC;
                count_d = '0;
                acc_d   = '0;
                ovf_d   = 1'b0;
            end
            ACC: if (bus.in_valid) begin
                acc_d   = sum;
                ovf_d   = ovf_q | cout;
                count_d = count_q + CNT_W'(1);
                state_d = (count_q == LAST) ? DONE : ACC;
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags decode straight from the state register: no input-to-output paths.
    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == DONE);
    assign bus.acc_out   = acc_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed plus random stimulus on an 8-bit and a 5-bit
// accumulator in lockstep, checked against a transaction-level model.
module tb_mac_accumulator;

    localparam int N = 4;

    typedef enum {M_IDLE, M_ACC, M_DONE} mode_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] product = '0;

    int    checks = 0;
    int    failures = 0;
    mode_t mode = M_IDLE;
    int    terms[$];

    always #5 clk = ~clk;

    mac_accumulator_if #(.ACC_W(8)) b8();
    mac_accumulator_if #(.ACC_W(5)) b5();

    assign b8.start = start;
    assign b8.in_valid = in_valid;
    assign b8.product = product;
    assign b8.out_ready = out_ready;
    assign b5.start = start;
    assign b5.in_valid = in_valid;
    assign b5.product = product;
    assign b5.out_ready = out_ready;

    mac_accumulator #(.ACC_W(8), .N_TERMS(N)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    mac_accumulator #(.ACC_W(5), .N_TERMS(N)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int total();
        int s = 0;
        foreach (terms[i]) s += terms[i];
        return s;
    endfunction

    task automatic compare_all();
        int s = total();
        check("in_ready8", 32'(b8.in_ready), 32'(mode == M_ACC));
        check("out_valid8", 32'(b8.out_valid), 32'(mode == M_DONE));
        check("acc8", 32'(b8.acc_out), s % 256);
        check("ovf8", 32'(b8.overflow), 32'(s >= 256));
        check("in_ready5", 32'(b5.in_ready), 32'(mode == M_ACC));
        check("out_valid5", 32'(b5.out_valid), 32'(mode == M_DONE));
        check("acc5", 32'(b5.acc_out), s % 32);
        check("ovf5", 32'(b5.overflow), 32'(s >= 32));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            mode = M_IDLE;
            terms.delete();
        end else begin
            case (mode)
                M_IDLE: if (start) begin
                    mode = M_ACC;
                    terms.delete();
                end
                M_ACC: if (in_valid) begin
                    terms.push_back(int'(product));
                    if (terms.size() == N) mode = M_DONE;
                end
                M_DONE: if (out_ready) mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
        end
        #1;
        compare_all();
    endtask

    task automatic step(input logic s, input logic v, input logic [3:0] p, input logic r);
        start = s;
        in_valid = v;
        product = p;
        out_ready = r;
        tick();
    endtask

    initial begin
        step(0, 0, 0, 0);
        step(1, 1, 9, 1);
        rst_n = 1'b1;

        // nominal 3+6+9+2
        step(1, 0, 0, 0);
        step(0, 1, 3, 0);
        step(0, 1, 6, 0);
        step(0, 1, 9, 0);
        check("nom_not_done_yet", 32'(b8.out_valid), 0);
        step(0, 1, 2, 0);
        check("nom_sum", 32'(b8.acc_out), 20);
        check("nom_ovf", 32'(b8.overflow), 0);
        check("nom_valid", 32'(b8.out_valid), 1);
        step(0, 0, 0, 1);
        check("nom_idle", 32'(b8.out_valid), 0);

        // wrap on the 5-bit instance
        step(1, 0, 0, 0);
        repeat (4) step(0, 1, 9, 0);
        check("wrap_acc5", 32'(b5.acc_out), 4);
        check("wrap_ovf5", 32'(b5.overflow), 1);
        check("wrap_acc8", 32'(b8.acc_out), 36);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        check("wrap_clear_ovf", 32'(b5.overflow), 0);
        check("wrap_clear_acc", 32'(b5.acc_out), 0);

        // stalls then backpressure
        step(0, 1, 1, 0);
        repeat (3) step(0, 0, 7, 0);
        step(0, 1, 4, 0);
        step(0, 1, 4, 0);
        step(0, 1, 9, 0);
        repeat (5) step(0, 1, 5, 0);
        check("stall_sum", 32'(b8.acc_out), 18);
        check("stall_hold_valid", 32'(b8.out_valid), 1);
        step(0, 0, 0, 1);

        // ignored inputs: valid in IDLE, start in ACC and DONE
        step(0, 1, 9, 0);
        step(0, 1, 9, 0);
        step(1, 1, 9, 0);
        step(1, 1, 5, 0);
        step(1, 0, 0, 0);
        step(0, 1, 5, 0);
        step(1, 1, 5, 0);
        step(0, 1, 5, 0);
        check("ign_sum", 32'(b8.acc_out), 20);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(0, 1, 9, 0);
        check("ign_idle_ready", 32'(b8.in_ready), 0);
        check("ign_idle_acc", 32'(b8.acc_out), 20);

        // async reset mid-operation
        step(1, 0, 0, 0);
        step(0, 1, 3, 0);
        step(0, 1, 4, 0);
        check("rst_pre_acc", 32'(b8.acc_out), 7);
        #2 rst_n = 1'b0;
        #1;
        mode = M_IDLE;
        terms.delete();
        compare_all();
        check("rst_async_acc", 32'(b8.acc_out), 0);
        step(0, 1, 3, 0);
        rst_n = 1'b1;
        step(1, 0, 0, 0);
        repeat (4) step(0, 1, 1, 0);
        check("rst_after_sum", 32'(b8.acc_out), 4);

        // back-to-back, second start at the earliest legal cycle
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0);
        check("b2b_sum", 32'(b8.acc_out), 0);
        check("b2b_valid", 32'(b8.out_valid), 1);

        for (int k = 0; k < 600; k++)
            step(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), logic'($urandom_range(0, 2) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
